sg13g2_gpio_ctrl: RTL and testbench
===================================

SG13G2_GPIO_CTRL -- requirements
Module: sg13g2_gpio_ctrl

Interface
REQ-001 Parameter NPADS, default 8: number of bidirectional pad channels.
REQ-002 Parameter DEB_W, default 8: debounce counter and threshold width.
REQ-003 Port clk, input, 1: single clock; every register SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port out_val, input, NPADS: core-requested pad drive values.
REQ-006 Port out_en, input, NPADS: core-requested pad drive enables.
REQ-007 Port c2p, output, NPADS: drive data to the pad cells.
REQ-008 Port c2p_en, output, NPADS: drive enable to the pad cells.
REQ-009 Port p2c, input, NPADS: raw asynchronous pad input from the pad cells.
REQ-010 Port deb_cnt, input, DEB_W: debounce threshold in cycles; 0 bypasses debouncing.
REQ-011 Port in_val, output, NPADS: synchronised, debounced pad level.
REQ-012 Port rise_evt, output, NPADS: sticky rising-edge flags.
REQ-013 Port fall_evt, output, NPADS: sticky falling-edge flags.
REQ-014 Port evt_clr, input, NPADS: per-pad single-cycle clear of both event flags.
REQ-015 Port irq_mask, input, NPADS: per-pad interrupt enable.
REQ-016 Port irq, output, 1: OR over all pads of (rise_evt|fall_evt)&irq_mask.

Function
REQ-017 c2p SHALL register out_val with 1-cycle latency.
REQ-018 Enable deassertion: if out_en[i] falls, c2p_en[i] SHALL fall at the next edge (1-cycle latency).
REQ-019 Enable assertion: if out_en[i] rises, c2p_en[i] SHALL rise 2 edges later, so c2p is stable for at least 1 cycle before drive.
REQ-020 Enable assertion: if out_en[i] falls again during that 2-cycle window, c2p_en[i] SHALL NOT assert.
REQ-021 Each p2c bit SHALL pass through a 2-flop synchroniser; its second stage is s[i].
REQ-022 Each pad SHALL own a DEB_W-bit counter cnt[i].
REQ-023 At each edge where s[i]==in_val[i], cnt[i] SHALL be set to 0.
REQ-024 At each edge where s[i]!=in_val[i] and cnt[i]>=deb_cnt, in_val[i] SHALL take s[i] and cnt[i] SHALL be set to 0.
REQ-025 At each edge where s[i]!=in_val[i] and cnt[i]<deb_cnt, cnt[i] SHALL increment.
REQ-026 Debounce latency: for a p2c change settling before edge 1, in_val SHALL update at edge 3+deb_cnt.
REQ-027 Glitch rejection: a p2c change shorter than deb_cnt+1 synchronised cycles SHALL NOT change in_val.
REQ-028 deb_cnt changing mid-count SHALL apply from the next edge; the >= comparison covers cnt already above the new threshold.
REQ-029 cnt SHALL never wrap, because it never exceeds deb_cnt.
REQ-030 An in_val 0->1 update SHALL set rise_evt; a 1->0 update SHALL set fall_evt, in the same edge as the in_val update.
REQ-031 evt_clr[i] SHALL clear rise_evt[i] and fall_evt[i] at the next edge.
REQ-032 If an event is set and cleared in the same cycle, the set SHALL win.
REQ-033 irq SHALL be combinational from the registered flags and irq_mask.

Reset
REQ-034 While rst is high at an edge, the following SHALL go to 0: c2p, c2p_en, both synchroniser stages, in_val, cnt, rise_evt, fall_evt, and the pending-enable state.
REQ-035 Reset asserted mid-operation SHALL release every pad drive at that edge, and SHALL abort any in-progress debounce count.
REQ-036 A pad held high through reset SHALL produce in_val=1 and rise_evt=1 at edge 3+deb_cnt after rst falls; this is intended behaviour.

Structure
REQ-037 Package sg13g2_gpio_pkg SHALL hold the NPADS and DEB_W default constants and the per-channel output enable state typedef (IDLE, ARM, DRIVE).
REQ-038 Sub-module sg13g2_gpio_in_chan SHALL implement one pad's synchroniser, debouncer and event flags, instantiated NPADS times.
REQ-039 The output path and the irq reduction SHALL live in the top level.

Verification
REQ-040 With deb_cnt=0, p2c[0] 0->1 before edge 1 -> in_val[0]=1 and rise_evt[0]=1 at edge 3, and irq=1 when irq_mask[0]=1.
REQ-041 With deb_cnt=4, a 3-cycle p2c[1] high pulse -> in_val[1] stays 0 with no event; a held high -> in_val[1]=1 at edge 7.
REQ-042 Set out_val[2]=1 and out_en[2]=1 at edge 0 -> c2p[2]=1 at edge 1 and c2p_en[2]=1 at edge 2; drop out_en[2] -> c2p_en[2]=0 one edge later.
REQ-043 out_en[3] pulsed high for 1 cycle -> c2p_en[3] never asserts.
REQ-044 evt_clr[0] asserted in the same cycle as a new fall_evt[0] set -> fall_evt[0]=1 afterwards.
REQ-045 rst asserted while c2p_en=all-ones and a debounce is in progress -> all outputs 0 at the next edge, and no stale in_val update after rst falls.

Source files
------------

// File: rtl/sg13g2_gpio_pkg.sv
// Shared defaults and the per-channel output-enable state for the GPIO controller.
package sg13g2_gpio_pkg;

    localparam int unsigned NPADS_DEF = 8;
    localparam int unsigned DEB_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        DRIVE = 2'd2
    } oe_state_e;

endpackage

// File: rtl/sg13g2_gpio_in_chan.sv
// One pad input channel: 2-flop synchroniser, counter debouncer, sticky edge flags.
module sg13g2_gpio_in_chan
    import sg13g2_gpio_pkg::*;
#(
    parameter int unsigned DEB_W = DEB_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p2c_i,
    input  logic [DEB_W-1:0] deb_cnt_i,
    input  logic             evt_clr_i,
    output logic             in_val_o,
    output logic             rise_evt_o,
    output logic             fall_evt_o
);

    logic             sync1_q;
    logic             s_q;
    logic             in_q,   in_d;
    logic [DEB_W-1:0] cnt_q,  cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             rise_set;
    logic             fall_set;

    // The >= compare lets a lowered threshold take effect even if cnt is already past it.
    always_comb begin
        in_d     = in_q;
        cnt_d    = cnt_q;
        rise_set = 1'b0;
        fall_set = 1'b0;
        if (s_q == in_q) begin
            cnt_d = '0;
        end else if (cnt_q >= deb_cnt_i) begin
            in_d     = s_q;
            cnt_d    = '0;
            rise_set = s_q;
            fall_set = ~s_q;
        end else begin
            cnt_d = cnt_q + DEB_W'(1);
        end
        rise_d = (rise_q & ~evt_clr_i) | rise_set;
        fall_d = (fall_q & ~evt_clr_i) | fall_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            in_q    <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= p2c_i;
            s_q     <= sync1_q;
            in_q    <= in_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign in_val_o   = in_q;
    assign rise_evt_o = rise_q;
    assign fall_evt_o = fall_q;

endmodule

// File: rtl/sg13g2_gpio_ctrl.sv
// GPIO pad controller: registered output drive with delayed enable, debounced inputs, irq.
module sg13g2_gpio_ctrl
    import sg13g2_gpio_pkg::*;
#(
    parameter int unsigned NPADS = NPADS_DEF,
    parameter int unsigned DEB_W = DEB_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPADS-1:0] out_val,
    input  logic [NPADS-1:0] out_en,
    output logic [NPADS-1:0] c2p,
    output logic [NPADS-1:0] c2p_en,
    input  logic [NPADS-1:0] p2c,
    input  logic [DEB_W-1:0] deb_cnt,
    output logic [NPADS-1:0] in_val,
    output logic [NPADS-1:0] rise_evt,
    output logic [NPADS-1:0] fall_evt,
    input  logic [NPADS-1:0] evt_clr,
    input  logic [NPADS-1:0] irq_mask,
    output logic             irq
);

    logic [NPADS-1:0] c2p_q;
    logic [NPADS-1:0] c2p_en_q;
    oe_state_e        oe_q [NPADS];

    // ARM delays the enable one cycle so c2p settles before the pad starts driving.
    always_ff @(posedge clk) begin
        if (rst) begin
            c2p_q    <= '0;
            c2p_en_q <= '0;
            for (int unsigned i = 0; i < NPADS; i++) begin
                oe_q[i] <= IDLE;
            end
        end else begin
            c2p_q <= out_val;
            for (int unsigned i = 0; i < NPADS; i++) begin
                case (oe_q[i])
                    IDLE: begin
                        if (out_en[i]) oe_q[i] <= ARM;
                    end
                    ARM: begin
                        if (out_en[i]) begin
                            oe_q[i]     <= DRIVE;
                            c2p_en_q[i] <= 1'b1;
                        end else begin
                            oe_q[i]     <= IDLE;
                        end
                    end
                    DRIVE: begin
                        if (!out_en[i]) begin
                            oe_q[i]     <= IDLE;
                            c2p_en_q[i] <= 1'b0;
                        end
                    end
                    default: begin
                        oe_q[i]     <= IDLE;
                        c2p_en_q[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign c2p    = c2p_q;
    assign c2p_en = c2p_en_q;

    for (genvar g = 0; g < NPADS; g++) begin : g_in
        sg13g2_gpio_in_chan #(
            .DEB_W (DEB_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .p2c_i      (p2c[g]),
            .deb_cnt_i  (deb_cnt),
            .evt_clr_i  (evt_clr[g]),
            .in_val_o   (in_val[g]),
            .rise_evt_o (rise_evt[g]),
            .fall_evt_o (fall_evt[g])
        );
    end

    assign irq = |((rise_evt | fall_evt) & irq_mask);

endmodule

// File: tb/tb_sg13g2_gpio_ctrl.sv
// Self-checking bench for sg13g2_gpio_ctrl: directed scenarios plus randomized run against a reference model.
module tb_sg13g2_gpio_ctrl;

    localparam int NPADS = 8;
    localparam int DEB_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NPADS-1:0] out_val, out_en, c2p, c2p_en, p2c;
    logic [DEB_W-1:0] deb_cnt;
    logic [NPADS-1:0] in_val, rise_evt, fall_evt, evt_clr, irq_mask;
    logic             irq;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [NPADS-1:0] m_c2p, m_en, m_prev_oe, m_d1, m_d2, m_in, m_rise, m_fall;
    int               m_run [NPADS];

    sg13g2_gpio_ctrl #(
        .NPADS (NPADS),
        .DEB_W (DEB_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_val  (out_val),
        .out_en   (out_en),
        .c2p      (c2p),
        .c2p_en   (c2p_en),
        .p2c      (p2c),
        .deb_cnt  (deb_cnt),
        .in_val   (in_val),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt),
        .evt_clr  (evt_clr),
        .irq_mask (irq_mask),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Drive enable only after out_en has been seen high on two consecutive edges;
    // input level changes once the synchronised value has disagreed for deb_cnt+1 edges.
    task automatic model_edge();
        logic [NPADS-1:0] new_rise;
        logic [NPADS-1:0] new_fall;
        new_rise = '0;
        new_fall = '0;
        if (rst) begin
            m_c2p = '0; m_en = '0; m_prev_oe = '0; m_d1 = '0; m_d2 = '0;
            m_in = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < NPADS; i++) m_run[i] = 0;
        end else begin
            m_c2p     = out_val;
            m_en      = out_en & m_prev_oe;
            m_prev_oe = out_en;
            for (int i = 0; i < NPADS; i++) begin
                if (m_d2[i] === m_in[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i] >= int'(deb_cnt)) begin
                    m_in[i]  = m_d2[i];
                    m_run[i] = 0;
                    if (m_d2[i]) new_rise[i] = 1'b1;
                    else         new_fall[i] = 1'b1;
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
            end
            m_rise = (m_rise & ~evt_clr) | new_rise;
            m_fall = (m_fall & ~evt_clr) | new_fall;
            m_d2   = m_d1;
            m_d1   = p2c;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; out_val = '0; out_en = '0; p2c = '0; evt_clr = '0;
        irq_mask = '0; deb_cnt = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; out_val = '1; out_en = '1; p2c = '1; evt_clr = '0;
        irq_mask = '1; deb_cnt = '0;
        step();
        step();
        checks++; if (c2p !== '0)      begin errors++; $display("FAIL reset_c2p got=%h exp=00", c2p); end
        checks++; if (c2p_en !== '0)   begin errors++; $display("FAIL reset_c2p_en got=%h exp=00", c2p_en); end
        checks++; if (in_val !== '0)   begin errors++; $display("FAIL reset_in_val got=%h exp=00", in_val); end
        checks++; if (rise_evt !== '0) begin errors++; $display("FAIL reset_rise got=%h exp=00", rise_evt); end
        checks++; if (fall_evt !== '0) begin errors++; $display("FAIL reset_fall got=%h exp=00", fall_evt); end
        checks++; if (irq !== 1'b0)    begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        do_reset();
    endtask

    task automatic test_deb_bypass();
        do_reset();
        deb_cnt = '0; irq_mask = 8'h01;
        p2c[0] = 1'b1;
        step();
        step();
        checks++; if (in_val[0] !== 1'b0) begin errors++; $display("FAIL bypass_early got=%b exp=0", in_val[0]); end
        step();
        checks++; if (in_val[0] !== 1'b1)   begin errors++; $display("FAIL bypass_in_val got=%b exp=1", in_val[0]); end
        checks++; if (rise_evt[0] !== 1'b1) begin errors++; $display("FAIL bypass_rise got=%b exp=1", rise_evt[0]); end
        checks++; if (irq !== 1'b1)         begin errors++; $display("FAIL bypass_irq got=%b exp=1", irq); end
        irq_mask = '0;
        #1;
        checks++; if (irq !== 1'b0)         begin errors++; $display("FAIL bypass_irq_masked got=%b exp=0", irq); end
    endtask

    task automatic test_glitch();
        do_reset();
        deb_cnt = 8'd4;
        p2c[1] = 1'b1;
        repeat (3) step();
        p2c[1] = 1'b0;
        repeat (10) step();
        checks++; if (in_val[1] !== 1'b0)   begin errors++; $display("FAIL glitch_in_val got=%b exp=0", in_val[1]); end
        checks++; if (rise_evt[1] !== 1'b0) begin errors++; $display("FAIL glitch_rise got=%b exp=0", rise_evt[1]); end
        p2c[1] = 1'b1;
        repeat (6) step();
        checks++; if (in_val[1] !== 1'b0)   begin errors++; $display("FAIL held_edge6 got=%b exp=0", in_val[1]); end
        step();
        checks++; if (in_val[1] !== 1'b1)   begin errors++; $display("FAIL held_edge7 got=%b exp=1", in_val[1]); end
        checks++; if (rise_evt[1] !== 1'b1) begin errors++; $display("FAIL held_rise got=%b exp=1", rise_evt[1]); end
    endtask

    task automatic test_output_enable();
        do_reset();
        out_val[2] = 1'b1; out_en[2] = 1'b1;
        step();
        checks++; if (c2p[2] !== 1'b1)    begin errors++; $display("FAIL oe_c2p_e1 got=%b exp=1", c2p[2]); end
        checks++; if (c2p_en[2] !== 1'b0) begin errors++; $display("FAIL oe_en_e1 got=%b exp=0", c2p_en[2]); end
        step();
        checks++; if (c2p_en[2] !== 1'b1) begin errors++; $display("FAIL oe_en_e2 got=%b exp=1", c2p_en[2]); end
        out_en[2] = 1'b0;
        step();
        checks++; if (c2p_en[2] !== 1'b0) begin errors++; $display("FAIL oe_release got=%b exp=0", c2p_en[2]); end
        out_en[3] = 1'b1;
        step();
        out_en[3] = 1'b0;
        step();
        checks++; if (c2p_en[3] !== 1'b0) begin errors++; $display("FAIL oe_pulse_e2 got=%b exp=0", c2p_en[3]); end
        step();
        checks++; if (c2p_en[3] !== 1'b0) begin errors++; $display("FAIL oe_pulse_e3 got=%b exp=0", c2p_en[3]); end
    endtask

    task automatic test_clear_race();
        do_reset();
        deb_cnt = '0;
        p2c[0] = 1'b1;
        repeat (3) step();
        evt_clr[0] = 1'b1;
        step();
        evt_clr[0] = 1'b0;
        checks++; if (rise_evt[0] !== 1'b0) begin errors++; $display("FAIL clr_rise got=%b exp=0", rise_evt[0]); end
        p2c[0] = 1'b0;
        step();
        step();
        evt_clr[0] = 1'b1;
        step();
        evt_clr[0] = 1'b0;
        checks++; if (fall_evt[0] !== 1'b1) begin errors++; $display("FAIL race_fall got=%b exp=1", fall_evt[0]); end
        checks++; if (in_val[0] !== 1'b0)   begin errors++; $display("FAIL race_in_val got=%b exp=0", in_val[0]); end
        evt_clr[0] = 1'b1;
        step();
        evt_clr[0] = 1'b0;
        checks++; if (fall_evt[0] !== 1'b0) begin errors++; $display("FAIL clr_fall got=%b exp=0", fall_evt[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        deb_cnt = 8'd4; out_en = '1; out_val = 8'hA5; p2c[1] = 1'b1; irq_mask = '1;
        step();
        step();
        checks++; if (c2p_en !== '1) begin errors++; $display("FAIL mid_en_on got=%h exp=ff", c2p_en); end
        repeat (3) step();
        checks++; if (in_val[1] !== 1'b0) begin errors++; $display("FAIL mid_counting got=%b exp=0", in_val[1]); end
        rst = 1'b1; p2c = '0;
        step();
        checks++; if (c2p_en !== '0) begin errors++; $display("FAIL mid_en_off got=%h exp=00", c2p_en); end
        checks++; if (c2p !== '0)    begin errors++; $display("FAIL mid_c2p got=%h exp=00", c2p); end
        checks++; if (in_val !== '0) begin errors++; $display("FAIL mid_in_val got=%h exp=00", in_val); end
        rst = 1'b0; out_en = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (in_val !== '0 || rise_evt !== '0 || irq !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale k=%0d in_val=%h rise=%h irq=%b exp=0", k, in_val, rise_evt, irq);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        irq_mask = NPADS'($urandom);
        for (int n = 0; n < 1500; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            out_val = NPADS'($urandom);
            out_en  = out_en ^ NPADS'($urandom & $urandom);
            p2c     = p2c ^ NPADS'($urandom & $urandom & $urandom);
            evt_clr = NPADS'($urandom & $urandom & $urandom);
            if (n % 100 == 0) irq_mask = NPADS'($urandom);
            if (n % 250 == 0) deb_cnt  = DEB_W'($urandom_range(0, 5));
            step();
            checks++; if (c2p !== m_c2p)       begin errors++; $display("FAIL rnd_c2p n=%0d got=%h exp=%h", n, c2p, m_c2p); end
            checks++; if (c2p_en !== m_en)     begin errors++; $display("FAIL rnd_c2p_en n=%0d got=%h exp=%h", n, c2p_en, m_en); end
            checks++; if (in_val !== m_in)     begin errors++; $display("FAIL rnd_in_val n=%0d got=%h exp=%h", n, in_val, m_in); end
            checks++; if (rise_evt !== m_rise) begin errors++; $display("FAIL rnd_rise n=%0d got=%h exp=%h", n, rise_evt, m_rise); end
            checks++; if (fall_evt !== m_fall) begin errors++; $display("FAIL rnd_fall n=%0d got=%h exp=%h", n, fall_evt, m_fall); end
            checks++;
            if (irq !== |((m_rise | m_fall) & irq_mask)) begin
                errors++;
                $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, irq, |((m_rise | m_fall) & irq_mask));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_deb_bypass();
        test_glitch();
        test_output_enable();
        test_clear_race();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
